// File: rtl/lsu_seq_rv32i_if.sv
// ---------------------------------------------------------------------------
// lsu_seq_rv32i_if
// Bundles the two sides of the load/store sequencer into one interface:
//   - datapath side:
//       ls_load, ls_store, ls_loadtype, ls_storetype, ls_addr and ls_wdata
//       go into the LSU;
//       ls_stall, ls_done, ls_rdata, ls_fault and ls_fault_code come back.
//   - memory side:
//       mem_req, mem_we, mem_addr, mem_be and mem_wdata go out of the LSU;
//       mem_ack and mem_rdata come back.
// Modports:
//   master : the sequencer itself (drives the memory request bus).
//   slave  : the environment, i.e. the datapath plus the data memory.
// ---------------------------------------------------------------------------
interface lsu_seq_rv32i_if;
   logic        ls_load;
   logic        ls_store;
   logic [2:0]  ls_loadtype;
   logic [1:0]  ls_storetype;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_stall;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        ls_fault;
   logic [1:0]  ls_fault_code;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      input  ls_load, ls_store, ls_loadtype, ls_storetype, ls_addr, ls_wdata,
      input  mem_ack, mem_rdata,
      output ls_stall, ls_done, ls_rdata, ls_fault, ls_fault_code,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport slave (
      output ls_load, ls_store, ls_loadtype, ls_storetype, ls_addr, ls_wdata,
      output mem_ack, mem_rdata,
      input  ls_stall, ls_done, ls_rdata, ls_fault, ls_fault_code,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_seq_rv32i.sv
// ---------------------------------------------------------------------------
// lsu_seq_rv32i
// Multi-cycle load/store sequencer between the RV32I execute stage and a
// req/ack data memory. An access is checked for an illegal type or
// misalignment in IDLE. A clean access then issues one word-aligned request
// with byte enables. The sequencer waits up to TIMEOUT cycles for mem_ack and
// then reports completion with a one-cycle ls_done pulse. Load data comes back
// sign- or zero-extended.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high
//   bus   - lsu_seq_rv32i_if.master. Carries the datapath controls and
//           results, plus the memory req/ack bus.
// All outputs are registered except ls_stall, which is combinational. This
// lets the PC freeze in the same cycle that the request is presented.
// ---------------------------------------------------------------------------
module lsu_seq_rv32i #(
   parameter int TIMEOUT = 16
) (
   input  logic            clock,
   input  logic            reset,
   lsu_seq_rv32i_if.master bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        ls_done_q, ls_done_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        ls_fault_q, ls_fault_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic [2:0]  ltype_q, ltype_d;      // load type kept for the extension in REQ
   logic [1:0]  lane_q, lane_d;        // byte offset kept for lane selection
   logic        is_load_q, is_load_d;

   // Decode of the request presented in IDLE; size_log2: 0 byte, 1 half, 2 word
   logic [1:0]  size_log2;
   logic        illegal;
   logic        misaligned;

   function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'd0:    byte_en = 4'b0001 << lo;
         2'd1:    byte_en = lo[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   // Replicate store data so that every enabled lane carries the right bytes
   function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'd0:    store_lanes = {4{d[7:0]}};
         2'd1:    store_lanes = {2{d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] lt,
                                               input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (lt)
         3'b000:  load_extend = {{24{b[7]}}, b};
         3'b001:  load_extend = {{16{h[15]}}, h};
         3'b011:  load_extend = {24'd0, b};
         3'b100:  load_extend = {16'd0, h};
         default: load_extend = w;
      endcase
   endfunction

   always_comb begin
      size_log2 = 2'd2;
      illegal   = 1'b0;
      if (bus.ls_load && bus.ls_store) begin
         illegal = 1'b1;
      end else if (bus.ls_load) begin
         case (bus.ls_loadtype)
            3'b000, 3'b011: size_log2 = 2'd0;
            3'b001, 3'b100: size_log2 = 2'd1;
            3'b010:         size_log2 = 2'd2;
            default:        illegal   = 1'b1;
         endcase
      end else begin
         case (bus.ls_storetype)
            2'b00:   size_log2 = 2'd0;
            2'b01:   size_log2 = 2'd1;
            2'b10:   size_log2 = 2'd2;
            default: illegal   = 1'b1;
         endcase
      end
      misaligned = ((size_log2 == 2'd1) && bus.ls_addr[0]) ||
                   ((size_log2 == 2'd2) && (bus.ls_addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_req_d    = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      ls_done_d    = 1'b0;
      ls_rdata_d   = 32'd0;
      ls_fault_d   = 1'b0;
      fault_code_d = 2'b00;
      ltype_d      = ltype_q;
      lane_d       = lane_q;
      is_load_d    = is_load_q;
      case (state_q)
         IDLE: begin
            if (bus.ls_load || bus.ls_store) begin
               if (illegal || misaligned) begin
                  // Rejected before any memory traffic; report in the next cycle
                  state_d      = DONE;
                  ls_done_d    = 1'b1;
                  ls_fault_d   = 1'b1;
                  fault_code_d = illegal ? 2'b11 : 2'b01;
               end else begin
                  state_d     = REQ;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.ls_store;
                  mem_addr_d  = {bus.ls_addr[31:2], 2'b00};
                  mem_be_d    = byte_en(size_log2, bus.ls_addr[1:0]);
                  mem_wdata_d = bus.ls_store ? store_lanes(size_log2, bus.ls_wdata) : 32'd0;
                  ltype_d     = bus.ls_loadtype;
                  lane_d      = bus.ls_addr[1:0];
                  is_load_d   = bus.ls_load;
               end
            end
         end
         REQ: begin
            // An ack in the last allowed cycle takes priority over the timeout
            if (bus.mem_ack) begin
               state_d    = DONE;
               ls_done_d  = 1'b1;
               ls_rdata_d = is_load_q ? load_extend(bus.mem_rdata, ltype_q, lane_q) : 32'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = DONE;
               ls_done_d    = 1'b1;
               ls_fault_d   = 1'b1;
               fault_code_d = 2'b10;
            end else begin
               cnt_d     = cnt_q + 8'd1;
               mem_req_d = 1'b1;
            end
         end
         // Inputs are still held by the datapath here; ignore them
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_be_q     <= 4'd0;
         mem_wdata_q  <= 32'd0;
         ls_done_q    <= 1'b0;
         ls_rdata_q   <= 32'd0;
         ls_fault_q   <= 1'b0;
         fault_code_q <= 2'b00;
         ltype_q      <= 3'd0;
         lane_q       <= 2'd0;
         is_load_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         ls_done_q    <= ls_done_d;
         ls_rdata_q   <= ls_rdata_d;
         ls_fault_q   <= ls_fault_d;
         fault_code_q <= fault_code_d;
         ltype_q      <= ltype_d;
         lane_q       <= lane_d;
         is_load_q    <= is_load_d;
      end
   end

   assign bus.ls_stall = !reset &&
                         (((state_q == IDLE) && (bus.ls_load || bus.ls_store)) || (state_q == REQ));

   assign bus.ls_done       = ls_done_q;
   assign bus.ls_rdata      = ls_rdata_q;
   assign bus.ls_fault      = ls_fault_q;
   assign bus.ls_fault_code = fault_code_q;
   assign bus.mem_req       = mem_req_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_be        = mem_be_q;
   assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_seq_rv32i.sv
`timescale 1ns/1ps
module tb_lsu_seq_rv32i;
   localparam int TIMEOUT = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;

   lsu_seq_rv32i_if bus_if();

   lsu_seq_rv32i #(.TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  code;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
      logic [31:0] rd;
      int          reqs;
      int          done_c;
   } exp_t;

   typedef struct {
      logic [1:0]  code;
      logic        fault;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
      logic [31:0] addr;
      logic [31:0] rd;
      int          reqs;
      int          done_c;
      int          stall_err;
      int          stable_err;
   } obs_t;

   typedef struct {
      string       name;
      bit          ld;
      bit          st;
      logic [2:0]  lt;
      logic [1:0]  stp;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_n;
      exp_t        e;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Transaction-level reference: what an access should produce, from its size and offset
   function automatic exp_t model(input bit ld, input bit st, input logic [2:0] lt,
                                  input logic [1:0] stp, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int ack_n);
      exp_t        e;
      int          sz;
      int          lane;
      logic [31:0] mask;
      logic [31:0] val;
      e = '{default: 0};
      sz = 0;
      if (ld && !st)
         sz = (lt == 0 || lt == 3) ? 1 : (lt == 1 || lt == 4) ? 2 : (lt == 2) ? 4 : 0;
      else if (st && !ld)
         sz = (stp == 0) ? 1 : (stp == 1) ? 2 : (stp == 2) ? 4 : 0;
      lane = int'(addr[1:0]);
      if (sz == 0) begin
         e.code = 2'b11; e.done_c = 1; return e;
      end
      if ((lane % sz) != 0) begin
         e.code = 2'b01; e.done_c = 1; return e;
      end
      e.be = 4'(((1 << sz) - 1) << lane);
      e.we = st;
      if (st)
         for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
      if (ack_n >= 1 && ack_n <= TIMEOUT) begin
         e.reqs   = ack_n;
         e.done_c = ack_n + 1;
         if (ld) begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            val  = (rdata >> (8 * lane)) & mask;
            if ((lt == 0 || lt == 1) && val[8*sz-1]) val = val | ~mask;
            e.rd = val;
         end
      end else begin
         e.reqs   = TIMEOUT;
         e.done_c = TIMEOUT + 1;
         e.code   = 2'b10;
      end
      return e;
   endfunction

   function automatic vec_t mk(input string nm, input bit ld, input bit st, input logic [2:0] lt,
                               input logic [1:0] stp, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata, input int ack_n,
                               input logic [1:0] code, input logic [3:0] be, input logic we,
                               input logic [31:0] wd, input logic [31:0] rd, input int reqs,
                               input int done_c);
      vec_t v;
      v.name = nm; v.ld = ld; v.st = st; v.lt = lt; v.stp = stp;
      v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_n = ack_n;
      v.e.code = code; v.e.be = be; v.e.we = we; v.e.wd = wd; v.e.rd = rd;
      v.e.reqs = reqs; v.e.done_c = done_c;
      return v;
   endfunction

   // Entered just after a rising edge with the DUT idle; cycle 0 is the request cycle.
   // The memory acks in the ack_n-th request cycle (0 = never).
   task automatic run_txn(input bit ld, input bit st, input logic [2:0] lt, input logic [1:0] stp,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_n, input bit noise,
                          input int exp_done, output obs_t o);
      bit first;
      o = '{default: 0};
      o.done_c = -1;
      first = 1'b1;
      bus_if.ls_load = ld;      bus_if.ls_store = st;
      bus_if.ls_loadtype = lt;  bus_if.ls_storetype = stp;
      bus_if.ls_addr = addr;    bus_if.ls_wdata = wdata;
      bus_if.mem_rdata = rdata;
      for (int c = 0; c < TIMEOUT + 8; c++) begin
         bus_if.mem_ack = 1'b0;
         if (bus_if.mem_req === 1'b1) begin
            o.reqs++;
            if (first) begin
               o.be = bus_if.mem_be; o.we = bus_if.mem_we;
               o.wd = bus_if.mem_wdata; o.addr = bus_if.mem_addr;
               first = 1'b0;
            end else if ({o.be, o.we, o.wd, o.addr} !==
                         {bus_if.mem_be, bus_if.mem_we, bus_if.mem_wdata, bus_if.mem_addr}) begin
               o.stable_err++;
            end
            if (o.reqs == ack_n) bus_if.mem_ack = 1'b1;
         end else if (c == 0 && noise) begin
            bus_if.mem_ack = 1'b1;
         end
         if (bus_if.ls_done === 1'b1) begin
            o.done_c = c;
            o.code = bus_if.ls_fault_code; o.fault = bus_if.ls_fault; o.rd = bus_if.ls_rdata;
            bus_if.ls_load = 1'b0; bus_if.ls_store = 1'b0;
         end
         @(negedge clock);
         if (bus_if.ls_stall !== (c < exp_done)) o.stall_err++;
         @(posedge clock); #1;
         if (o.done_c >= 0) break;
      end
      bus_if.ls_load = 1'b0; bus_if.ls_store = 1'b0; bus_if.mem_ack = 1'b0;
   endtask

   task automatic compare(input string nm, input exp_t e, input logic [31:0] addr, input obs_t o);
      chk({nm, " done_cycle"}, 32'(o.done_c), 32'(e.done_c));
      chk({nm, " fault_code"}, 32'(o.code), 32'(e.code));
      chk({nm, " fault"}, 32'(o.fault), 32'(e.code != 2'b00));
      chk({nm, " rdata"}, o.rd, e.rd);
      chk({nm, " req_cycles"}, 32'(o.reqs), 32'(e.reqs));
      chk({nm, " stall_errors"}, 32'(o.stall_err), 32'd0);
      if (e.reqs > 0) begin
         chk({nm, " mem_be"}, 32'(o.be), 32'(e.be));
         chk({nm, " mem_we"}, 32'(o.we), 32'(e.we));
         chk({nm, " mem_wdata"}, o.wd, e.wd);
         chk({nm, " mem_addr"}, o.addr, {addr[31:2], 2'b00});
         chk({nm, " bus_unstable"}, 32'(o.stable_err), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[16];
      obs_t        o;
      exp_t        e;
      bit          ld, st, noise;
      logic [2:0]  lt;
      logic [1:0]  stp;
      logic [31:0] addr, wdata, rdata;
      int          ack_n;

      tbl[0]  = mk("sw_ack3",   0, 1, 3'd0, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 3,
                   2'b00, 4'hF, 1, 32'hDEADBEEF, 32'h0, 3, 4);
      tbl[1]  = mk("lb_203",    1, 0, 3'd0, 2'd0, 32'h203, 32'h0, 32'h80112233, 1,
                   2'b00, 4'h8, 0, 32'h0, 32'hFFFFFF80, 1, 2);
      tbl[2]  = mk("lbu_203",   1, 0, 3'd3, 2'd0, 32'h203, 32'h0, 32'h80112233, 1,
                   2'b00, 4'h8, 0, 32'h0, 32'h00000080, 1, 2);
      tbl[3]  = mk("lh_102",    1, 0, 3'd1, 2'd0, 32'h102, 32'h0, 32'h80017FFF, 1,
                   2'b00, 4'hC, 0, 32'h0, 32'hFFFF8001, 1, 2);
      tbl[4]  = mk("lhu_102",   1, 0, 3'd4, 2'd0, 32'h102, 32'h0, 32'h80017FFF, 1,
                   2'b00, 4'hC, 0, 32'h0, 32'h00008001, 1, 2);
      tbl[5]  = mk("sh_102",    0, 1, 3'd0, 2'd1, 32'h102, 32'h1234ABCD, 32'h0, 2,
                   2'b00, 4'hC, 1, 32'hABCDABCD, 32'h0, 2, 3);
      tbl[6]  = mk("lw_mis",    1, 0, 3'd2, 2'd0, 32'h101, 32'h0, 32'h0, 1,
                   2'b01, 4'h0, 0, 32'h0, 32'h0, 0, 1);
      tbl[7]  = mk("sh_mis",    0, 1, 3'd0, 2'd1, 32'h103, 32'h0, 32'h0, 1,
                   2'b01, 4'h0, 0, 32'h0, 32'h0, 0, 1);
      tbl[8]  = mk("lt_101",    1, 0, 3'd5, 2'd0, 32'h100, 32'h0, 32'h0, 1,
                   2'b11, 4'h0, 0, 32'h0, 32'h0, 0, 1);
      tbl[9]  = mk("sw_tmo",    0, 1, 3'd0, 2'd2, 32'h44, 32'h55AA55AA, 32'h0, 0,
                   2'b10, 4'hF, 1, 32'h55AA55AA, 32'h0, 16, 17);
      tbl[10] = mk("sw_ack16",  0, 1, 3'd0, 2'd2, 32'h48, 32'h01020304, 32'h0, 16,
                   2'b00, 4'hF, 1, 32'h01020304, 32'h0, 16, 17);
      tbl[11] = mk("both",      1, 1, 3'd2, 2'd2, 32'h100, 32'h0, 32'h0, 1,
                   2'b11, 4'h0, 0, 32'h0, 32'h0, 0, 1);
      tbl[12] = mk("sb_002",    0, 1, 3'd0, 2'd0, 32'h002, 32'h123456A5, 32'h0, 1,
                   2'b00, 4'h4, 1, 32'hA5A5A5A5, 32'h0, 1, 2);
      tbl[13] = mk("st_11",     0, 1, 3'd0, 2'd3, 32'h100, 32'h0, 32'h0, 1,
                   2'b11, 4'h0, 0, 32'h0, 32'h0, 0, 1);
      tbl[14] = mk("lw_300",    1, 0, 3'd2, 2'd0, 32'h300, 32'h0, 32'h89ABCDEF, 2,
                   2'b00, 4'hF, 0, 32'h0, 32'h89ABCDEF, 2, 3);
      tbl[15] = mk("lb_001",    1, 0, 3'd0, 2'd0, 32'h001, 32'h0, 32'h00007F00, 1,
                   2'b00, 4'h2, 0, 32'h0, 32'h0000007F, 1, 2);

      bus_if.ls_load = 1'b1; bus_if.ls_store = 1'b0;
      bus_if.ls_loadtype = 3'd2; bus_if.ls_storetype = 2'd0;
      bus_if.ls_addr = 32'h0; bus_if.ls_wdata = 32'h0;
      bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'h0;

      // Reset state; ls_stall must be held low even with a request present
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset stall", 32'(bus_if.ls_stall), 32'd0);
      chk("reset mem_req", 32'(bus_if.mem_req), 32'd0);
      chk("reset ls_done", 32'(bus_if.ls_done), 32'd0);
      chk("reset fault", {29'd0, bus_if.ls_fault, bus_if.ls_fault_code}, 32'd0);
      chk("reset ls_rdata", bus_if.ls_rdata, 32'd0);
      chk("reset mem_addr", bus_if.mem_addr, 32'd0);
      chk("reset mem_wdata", bus_if.mem_wdata, 32'd0);
      chk("reset be_we", {27'd0, bus_if.mem_we, bus_if.mem_be}, 32'd0);
      bus_if.ls_load = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 16; i++) begin
         run_txn(tbl[i].ld, tbl[i].st, tbl[i].lt, tbl[i].stp, tbl[i].addr, tbl[i].wdata,
                 tbl[i].rdata, tbl[i].ack_n, 1'b0, tbl[i].e.done_c, o);
         compare(tbl[i].name, tbl[i].e, tbl[i].addr, o);
      end

      // Reset in the second request cycle aborts the access without ls_done
      bus_if.ls_store = 1'b1; bus_if.ls_storetype = 2'd2;
      bus_if.ls_addr = 32'h40; bus_if.ls_wdata = 32'hCAFEF00D;
      @(posedge clock); #1;
      chk("rst_abort req_c1", 32'(bus_if.mem_req), 32'd1);
      @(posedge clock); #1;
      chk("rst_abort req_c2", 32'(bus_if.mem_req), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_abort stall_c2", 32'(bus_if.ls_stall), 32'd0);
      @(posedge clock); #1;
      chk("rst_abort req_c3", 32'(bus_if.mem_req), 32'd0);
      chk("rst_abort done_c3", 32'(bus_if.ls_done), 32'd0);
      @(negedge clock);
      chk("rst_abort stall_c3", 32'(bus_if.ls_stall), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      bus_if.ls_store = 1'b0;
      bus_if.mem_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         chk("late_ack req", 32'(bus_if.mem_req), 32'd0);
         chk("late_ack done", 32'(bus_if.ls_done), 32'd0);
      end
      bus_if.mem_ack = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = int'($urandom_range(0, 19));
         ld = (kind < 9) || (kind == 19);
         st = (kind >= 9);
         lt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         stp = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         addr = $urandom; wdata = $urandom; rdata = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (ld ? (lt == 3'd2) : (stp == 2'd2)) addr[1:0] = 2'b00;
            else if (ld ? (lt == 3'd1 || lt == 3'd4) : (stp == 2'd1)) addr[0] = 1'b0;
         end
         ack_n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
         noise = ($urandom_range(0, 1) == 1);
         e = model(ld, st, lt, stp, addr, wdata, rdata, ack_n);
         run_txn(ld, st, lt, stp, addr, wdata, rdata, ack_n, noise, e.done_c, o);
         compare($sformatf("rand%0d", i), e, addr, o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_seq_rv32i.md
Name: lsu_seq_rv32i

Overview:
- Multi-cycle load/store sequencer between the RV32I datapath and a data memory that uses a req/ack handshake.
- Takes the decoded load/store controls, effective address (ALU result) and rs2 data. Drives word-aligned memory requests with byte enables.
- Stalls the PC and register file until the access completes. Returns sign/zero-extended load data.
- Flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum number of cycles mem_req stays high waiting for mem_ack. Legal range 2..255; counter is 8 bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ls_load  in  1  load instruction in execute; held until ls_done.
- ls_store  in  1  store instruction in execute; held until ls_done.
- ls_loadtype  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
- ls_storetype  in  2  00 SB, 01 SH, 10 SW.
- ls_addr  in  32  effective byte address.
- ls_wdata  in  32  store data (rs2).
- ls_stall  out  1  freeze PC/regfile (combinational).
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  32  extended load data, valid while ls_done=1.
- ls_fault  out  1  asserted with ls_done when the access failed.
- ls_fault_code  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal type / both requests.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {ls_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accept/complete; sampled only while mem_req=1.
- mem_rdata  in  32  read word, valid when mem_ack=1.

Behaviour:
- FSM states: IDLE, REQ, DONE. All outputs are registered except ls_stall.
- Reset: state IDLE, counter 0, all registered outputs 0. ls_stall is forced 0 while reset=1.
- Reset in any state returns to IDLE on the next edge. mem_req drops that edge. No ls_done is generated for the aborted access.
- IDLE, when ls_load or ls_store is sampled (cycle 0):
  - Both high: go to DONE, fault 11.
  - Invalid type (loadtype 101..111, storetype 11): go to DONE, fault 11.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to DONE, fault 01.
  - Otherwise: go to REQ, latch mem_we/mem_addr/mem_be/mem_wdata, clear the counter.
- ls_stall = (state==IDLE & (ls_load|ls_store)) | state==REQ. It is low in DONE, so the PC advances at the end of the DONE cycle.
- Byte enables:
  - Byte access: be = 4'b0001 << addr[1:0].
  - Half access: be = addr[1] ? 1100 : 0011.
  - Word access: be = 1111.
- mem_wdata: SB replicates byte[7:0] ×4; SH replicates half[15:0] ×2; SW passes through.
- Loads drive mem_we=0. mem_wdata is don't-care for loads but is driven 0.
- REQ:
  - mem_req=1; mem_we/addr/be/wdata are held stable.
  - mem_ack=1: capture and extend read data, go to DONE with no fault.
  - Else if counter==TIMEOUT-1: go to DONE with fault 10.
  - Else: counter+1.
  - mem_req is therefore high for at most TIMEOUT cycles. An ack in the final cycle wins over the timeout.
- Load extraction: select the byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Stores return ls_rdata=0.
- DONE (one cycle):
  - ls_done=1; ls_fault=(code!=00).
  - On any fault, ls_rdata=0 and no mem_req was ever issued for misaligned or illegal accesses.
  - Next state is always IDLE. Inputs are ignored in DONE, so the same still-held instruction is not re-issued.
- Latency: request seen in cycle 0; mem_req high in cycle 1. Ack in cycle k≥1 gives ls_done in cycle k+1. A fault detected in IDLE gives ls_done in cycle 1.
- mem_ack outside REQ is ignored.
- The datapath suppresses the rd write when ls_fault=1.

Test Plan:
- SW, addr 0x100, wdata 0xDEADBEEF, ack in the 3rd REQ cycle -> mem_addr 0x100, be 1111, we 1, mem_req high cycles 1-3, ls_stall high cycles 0-3, ls_done cycle 4, fault 0.
- LB, addr 0x203, mem_rdata 0x80112233, ack in cycle 1 -> be 1000, ls_rdata 0xFFFFFF80, ls_done cycle 2. Repeated as LBU -> 0x00000080.
- LH, addr 0x102, mem_rdata 0x80017FFF -> be 1100, ls_rdata 0xFFFF8001; LHU -> 0x00008001. SH, addr 0x102, wdata 0x1234ABCD -> be 1100, mem_wdata 0xABCDABCD.
- LW addr 0x101; SH addr 0x103; loadtype 101 -> no mem_req, ls_done+ls_fault cycle 1, codes 01, 01, 11 respectively, ls_rdata 0.
- SW with mem_ack held 0 -> mem_req high exactly 16 cycles, then ls_done, fault code 10. Repeat with ack in the 16th cycle -> success, fault 0.
- reset asserted in the 2nd REQ cycle -> next cycle mem_req=0, ls_stall=0 while reset high, no ls_done. A late mem_ack after reset has no effect.
